// File: rtl/qsfp_link_sequencer.sv
// Two-channel QSFP link bring-up sequencer: core reset, wait for channel_up, qualify, monitor.
// Optional build macro QSFP_DROP_COUNT_EN enables the per-channel link-drop counters.
module qsfp_link_sequencer #(
    parameter int RESET_CYCLES  = 256,
    parameter int UP_TIMEOUT    = 1000000,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  ch_up,
    input  logic [1:0]  enable,
    input  logic [1:0]  force_reset,
    input  logic [1:0]  clear_stats,
    output logic [1:0]  core_reset,
    output logic [1:0]  link_good,
    output logic [1:0]  timeout_err,
    output logic [15:0] drop_count
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RESET   = 3'd1;
    localparam logic [2:0] ST_WAIT_UP = 3'd2;
    localparam logic [2:0] ST_QUALIFY = 3'd3;
    localparam logic [2:0] ST_UP      = 3'd4;

    // Each timed state lasts exactly N cycles: the counter starts at 0 on entry.
    localparam logic [31:0] RESET_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] UP_LAST     = 32'(UP_TIMEOUT - 1);
    localparam logic [31:0] STABLE_LAST = 32'(STABLE_CYCLES - 1);

    logic [1:0] sync1;
    logic [1:0] sync2;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= ch_up;
            sync2 <= sync1;
        end
    end

    // Per-channel FSM state, grouped for checker binding.
    logic [2:0] ch_state [2];
    logic [5:0] dbg_state;
    assign dbg_state = {ch_state[1], ch_state[0]};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic [2:0]  state;
        logic [2:0]  state_nxt;
        logic [31:0] cnt;
        logic        restart;
        logic        to_set;
        logic        drop_evt;
        logic        up;
        logic        core_reset_q;
        logic        link_good_q;
        logic        timeout_q;

        assign up          = sync2[i];
        assign ch_state[i] = state;

        // Priority: enable low, then force_reset (outside IDLE), then link events.
        always_comb begin
            state_nxt = state;
            restart   = 1'b0;
            to_set    = 1'b0;
            drop_evt  = 1'b0;
            if (!enable[i]) begin
                state_nxt = ST_IDLE;
            end else if (force_reset[i] && (state != ST_IDLE)) begin
                state_nxt = ST_RESET;
                restart   = 1'b1;
            end else begin
                case (state)
                    ST_IDLE: state_nxt = ST_RESET;
                    ST_RESET: begin
                        if (cnt == RESET_LAST) state_nxt = ST_WAIT_UP;
                    end
                    ST_WAIT_UP: begin
                        if (up) begin
                            state_nxt = ST_QUALIFY;
                        end else if (cnt == UP_LAST) begin
                            to_set    = 1'b1;
                            state_nxt = ST_RESET;
                        end
                    end
                    ST_QUALIFY: begin
                        if (!up) state_nxt = ST_WAIT_UP;
                        else if (cnt == STABLE_LAST) state_nxt = ST_UP;
                    end
                    ST_UP: begin
                        if (!up) begin
                            drop_evt  = 1'b1;
                            state_nxt = ST_RESET;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                state        <= ST_IDLE;
                cnt          <= 32'd0;
                core_reset_q <= 1'b1;
                link_good_q  <= 1'b0;
                timeout_q    <= 1'b0;
            end else begin
                state        <= state_nxt;
                cnt          <= (restart || (state_nxt != state)) ? 32'd0 : cnt + 32'd1;
                core_reset_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET);
                link_good_q  <= (state_nxt == ST_UP);
                if (to_set)              timeout_q <= 1'b1;
                else if (clear_stats[i]) timeout_q <= 1'b0;
            end
        end

        assign core_reset[i]  = core_reset_q;
        assign link_good[i]   = link_good_q;
        assign timeout_err[i] = timeout_q;

`ifdef QSFP_DROP_COUNT_EN
        logic [7:0] drop_q;

        always_ff @(posedge clk) begin
            if (!resetn) begin
                drop_q <= 8'd0;
            end else if (drop_evt) begin
                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end else if (clear_stats[i]) begin
                drop_q <= 8'd0;
            end
        end

        assign drop_count[8*i +: 8] = drop_q;
`else
        logic unused_drop_evt;
        assign unused_drop_evt      = drop_evt;
        assign drop_count[8*i +: 8] = 8'd0;
`endif
    end

endmodule

// File: tb/tb_qsfp_link_sequencer.sv
// Bench for qsfp_link_sequencer: directed scenarios then random traffic against a phase/countdown model.
module tb_qsfp_link_sequencer;

    localparam int RC = 4;
    localparam int UT = 20;
    localparam int SC = 3;
    localparam int W  = 22;

`ifdef QSFP_DROP_COUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  ch_up = 2'b00;
    logic [1:0]  enable = 2'b00;
    logic [1:0]  force_reset = 2'b00;
    logic [1:0]  clear_stats = 2'b00;
    logic [1:0]  core_reset;
    logic [1:0]  link_good;
    logic [1:0]  timeout_err;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    qsfp_link_sequencer #(
        .RESET_CYCLES (RC),
        .UP_TIMEOUT   (UT),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ch_up      (ch_up),
        .enable     (enable),
        .force_reset(force_reset),
        .clear_stats(clear_stats),
        .core_reset (core_reset),
        .link_good  (link_good),
        .timeout_err(timeout_err),
        .drop_count (drop_count)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // A link is in a phase with a number of cycles left before its timed event.
    localparam int P_IDLE = 0, P_RESET = 1, P_WAIT = 2, P_QUAL = 3, P_UP = 4;
    int         m_phase [2];
    int         m_left  [2];
    bit         m_to    [2];
    int         m_drops [2];
    logic [1:0] d1, d2;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] exp_vec();
        logic [1:0]  cr, lg, to;
        logic [15:0] dc;
        for (int c = 0; c < 2; c++) begin
            cr[c] = (m_phase[c] == P_IDLE) || (m_phase[c] == P_RESET);
            lg[c] = (m_phase[c] == P_UP);
            to[c] = m_to[c];
        end
        dc = DC_EN ? {8'(m_drops[1]), 8'(m_drops[0])} : 16'h0000;
        return {cr, lg, to, dc};
    endfunction

    task automatic model_edge();
        logic [1:0] seen;
        seen = d2;
        if (!resetn) begin
            d1 = 2'b00;
            d2 = 2'b00;
            for (int c = 0; c < 2; c++) begin
                m_phase[c] = P_IDLE; m_left[c] = 0; m_to[c] = 1'b0; m_drops[c] = 0;
            end
        end else begin
            d2 = d1;
            d1 = ch_up;
            for (int c = 0; c < 2; c++) begin
                bit bump, fired;
                bump = 1'b0; fired = 1'b0;
                if (!enable[c]) begin
                    m_phase[c] = P_IDLE;
                end else if (force_reset[c] && m_phase[c] != P_IDLE) begin
                    m_phase[c] = P_RESET; m_left[c] = RC;
                end else begin
                    case (m_phase[c])
                        P_IDLE: begin m_phase[c] = P_RESET; m_left[c] = RC; end
                        P_RESET: begin
                            m_left[c]--;
                            if (m_left[c] == 0) begin m_phase[c] = P_WAIT; m_left[c] = UT; end
                        end
                        P_WAIT: begin
                            if (seen[c]) begin
                                m_phase[c] = P_QUAL; m_left[c] = SC;
                            end else begin
                                m_left[c]--;
                                if (m_left[c] == 0) begin
                                    fired = 1'b1; m_to[c] = 1'b1;
                                    m_phase[c] = P_RESET; m_left[c] = RC;
                                end
                            end
                        end
                        P_QUAL: begin
                            if (!seen[c]) begin
                                m_phase[c] = P_WAIT; m_left[c] = UT;
                            end else begin
                                m_left[c]--;
                                if (m_left[c] == 0) m_phase[c] = P_UP;
                            end
                        end
                        default: begin
                            if (!seen[c]) begin
                                bump = 1'b1;
                                if (m_drops[c] < 255) m_drops[c]++;
                                m_phase[c] = P_RESET; m_left[c] = RC;
                            end
                        end
                    endcase
                end
                if (clear_stats[c]) begin
                    if (!fired) m_to[c] = 1'b0;
                    if (!bump) m_drops[c] = 0;
                end
            end
        end
        exp_q.push_back(exp_vec());
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        chk("core_reset",  16'(core_reset),  16'(e[21:20]));
        chk("link_good",   16'(link_good),   16'(e[19:18]));
        chk("timeout_err", 16'(timeout_err), 16'(e[17:16]));
        chk("drop_count",  drop_count,       e[15:0]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        resetn = 1'b0; enable = 2'b00; ch_up = 2'b00;
        force_reset = 2'b00; clear_stats = 2'b00;
        run(2);
        resetn = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_core_reset",  16'(core_reset),  16'h3);
        chk("rst_link_good",   16'(link_good),   16'h0);
        chk("rst_timeout_err", 16'(timeout_err), 16'h0);
        chk("rst_drop_count",  drop_count,       16'h0);

        // Bring-up with channel_up already high; channel 1 stays disabled.
        ch_up = 2'b01;
        run(3);
        enable = 2'b01;
        run(4);
        chk("bringup_in_reset", 16'(core_reset[0]), 16'h1);
        run(1);
        chk("bringup_reset_released", 16'(core_reset[0]), 16'h0);
        chk("bringup_ch1_in_reset",   16'(core_reset[1]), 16'h1);
        run(3);
        chk("bringup_qualifying", 16'(link_good[0]), 16'h0);
        run(1);
        chk("bringup_link_good", 16'(link_good), 16'h1);

        // WAIT_UP timeout and retry.
        do_reset();
        enable = 2'b01;
        run(24);
        chk("to_not_yet", 16'(timeout_err[0]), 16'h0);
        run(1);
        chk("to_set",      16'(timeout_err[0]), 16'h1);
        chk("to_reset_on", 16'(core_reset[0]),  16'h1);
        run(3);
        chk("to_reset_held", 16'(core_reset[0]), 16'h1);
        run(1);
        chk("to_reset_off", 16'(core_reset[0]),  16'h0);
        chk("to_sticky",    16'(timeout_err[0]), 16'h1);
        clear_stats = 2'b01;
        run(1);
        clear_stats = 2'b00;
        chk("to_cleared", 16'(timeout_err[0]), 16'h0);

        // Three link drops, then clear.
        do_reset();
        ch_up = 2'b01; enable = 2'b01;
        run(12);
        for (int k = 0; k < 3; k++) begin
            ch_up = 2'b00; run(2);
            ch_up = 2'b01; run(10);
        end
        chk("drops_3",        drop_count, DC_EN ? 16'd3 : 16'd0);
        chk("drops_link_up",  16'(link_good[0]), 16'h1);
        clear_stats = 2'b01;
        run(1);
        clear_stats = 2'b00;
        chk("drops_cleared", drop_count, 16'd0);

        // Saturation at 255.
        for (int k = 0; k < 260; k++) begin
            ch_up = 2'b00; run(2);
            ch_up = 2'b01; run(10);
        end
        chk("drops_saturate", drop_count, DC_EN ? 16'd255 : 16'd0);

        // One-cycle glitch while qualifying.
        do_reset();
        enable = 2'b01;
        run(5);
        ch_up = 2'b01; run(2);
        ch_up = 2'b00; run(1);
        ch_up = 2'b01; run(2);
        chk("glitch_no_link", 16'(link_good[0]), 16'h0);
        chk("glitch_no_drop", drop_count, 16'd0);
        run(6);
        chk("glitch_recovered", 16'(link_good[0]), 16'h1);

        // force_reset from UP, then enable low wins over force_reset.
        force_reset = 2'b01;
        run(1);
        force_reset = 2'b00;
        chk("force_reset_on", 16'(core_reset[0]), 16'h1);
        run(3);
        chk("force_reset_held", 16'(core_reset[0]), 16'h1);
        run(1);
        chk("force_reset_off", 16'(core_reset[0]), 16'h0);
        chk("force_no_drop",   drop_count, 16'd0);
        run(5);
        enable = 2'b00; force_reset = 2'b01;
        run(1);
        force_reset = 2'b00;
        chk("disable_link_down", 16'(link_good[0]), 16'h0);
        run(6);
        chk("disable_idle_reset", 16'(core_reset[0]), 16'h1);

        // Random traffic on both channels.
        enable = 2'b11;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(15) == 0) ch_up[c] = ~ch_up[c];
                force_reset[c] = ($urandom_range(99) == 0);
                clear_stats[c] = ($urandom_range(59) == 0);
            end
            if ($urandom_range(199) == 0) begin
                int k;
                k = $urandom_range(1);
                enable[k] = ~enable[k];
            end
            resetn = ($urandom_range(499) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qsfp_link_sequencer.md
QSFP_LINK_SEQUENCER -- requirements
Module: qsfp_link_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 256, meaning core_reset assertion length in clk cycles.
REQ-002 SHALL have parameter UP_TIMEOUT, default 1000000, meaning max cycles in WAIT_UP before retry.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, meaning consecutive synced channel-up cycles required before declaring link good.
REQ-004 SHALL have port clk  in  1  clock, all logic rising-edge.
REQ-005 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port ch_up  in  2  asynchronous channel_up per QSFP (bit0 = QSFP0, bit1 = QSFP1).
REQ-007 SHALL have port enable  in  2  per-channel sequencing enable, level.
REQ-008 SHALL have port force_reset  in  2  per-channel single-cycle restart request.
REQ-009 SHALL have port clear_stats  in  2  per-channel single-cycle clear of timeout_err and drop count.
REQ-010 SHALL have port core_reset  out  2  active-high reset to each transceiver core, registered.
REQ-011 SHALL have port link_good  out  2  channel qualified up, registered.
REQ-012 SHALL have port timeout_err  out  2  sticky WAIT_UP timeout flag, registered.
REQ-013 SHALL have port drop_count  out  16  bits[7:0] QSFP0, bits[15:8] QSFP1 link-drop counts, registered.

Function
REQ-014 SHALL pass each ch_up bit through a 2-flop synchronizer; all decisions use synced value (2-cycle latency).
REQ-015 SHALL run two independent identical FSMs, states IDLE, RESET, WAIT_UP, QUALIFY, UP, each with a 32-bit cycle counter cleared on every state entry.
REQ-016 IDLE: core_reset=1, link_good=0; enable=1 -> RESET.
REQ-017 RESET: core_reset=1; after exactly RESET_CYCLES cycles in RESET -> WAIT_UP.
REQ-018 WAIT_UP: core_reset=0; synced ch_up=1 -> QUALIFY; counter reaching UP_TIMEOUT with ch_up=0 -> set timeout_err, -> RESET.
REQ-019 QUALIFY: core_reset=0; synced ch_up=0 -> WAIT_UP (counter restarts); STABLE_CYCLES consecutive cycles of ch_up=1 -> UP.
REQ-020 UP: link_good=1; synced ch_up=0 -> increment drop count (saturating at 255), link_good=0 next cycle, -> RESET.
REQ-021 Priority per channel: enable=0 (-> IDLE from any state, next cycle) > force_reset (-> RESET from any non-IDLE state, including RESET, restarting count) > ch_up/counter events.
REQ-022 force_reset while in IDLE SHALL be ignored.
REQ-023 clear_stats coincident with timeout_err set or drop increment: set/increment wins; clear applies otherwise.
REQ-024 Channels SHALL NOT interact; simultaneous events on both channels handled in same cycle.

Reset
REQ-025 On resetn=0 at clk edge: both FSMs IDLE, core_reset=2'b11, link_good=0, timeout_err=0, drop_count=0, synchronizers=0, counters=0.
REQ-026 Reset mid-sequence SHALL abort with no drop count or timeout recorded.

Configuration
REQ-027 With QSFP_DROP_COUNT_EN defined, drop_count SHALL behave per REQ-020/023.
REQ-028 Without QSFP_DROP_COUNT_EN, drop_count SHALL be constant 0 and its counter logic SHALL be absent; all other behaviour unchanged.

Verification (RESET_CYCLES=4, UP_TIMEOUT=20, STABLE_CYCLES=3)
REQ-029 enable=2'b01, ch_up0 held 1 -> core_reset0 low 4 cycles after RESET entry, link_good0 high after sync+3 stable cycles; channel 1 stays in reset.
REQ-030 enable=2'b01, ch_up0 held 0 -> timeout_err0=1 after 20 WAIT_UP cycles, core_reset0 reasserts 4 cycles, retries.
REQ-031 link_good0=1, ch_up0 drops 3 times (recovering each) -> drop_count[7:0]=3; clear_stats0 pulse -> 0.
REQ-032 ch_up0 glitches 0 for 1 cycle in QUALIFY -> returns to WAIT_UP, link_good0 stays 0, drop_count unchanged.
REQ-033 force_reset0 in UP -> core_reset0=1 next cycle for 4 cycles, drop_count unchanged; enable0=0 same cycle -> IDLE wins.
REQ-034 Build without QSFP_DROP_COUNT_EN, repeat REQ-031 stimulus -> drop_count=0 throughout.
